// File: rtl/ras_spec_pkg.sv
// Shared fetch-predictor definitions: branch-type encodings, RAS checkpoint
// record and the return-address helper.
package ras_spec_pkg;

   localparam int RAS_DEPTH = 16;
   localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
   localparam int RAS_OCC_W = RAS_PTR_W + 1;

   localparam logic [2:0] BR_NOP  = 3'd0;
   localparam logic [2:0] BR_COND = 3'd1;
   localparam logic [2:0] BR_CALL = 3'd2;
   localparam logic [2:0] BR_RET  = 3'd3;
   localparam logic [2:0] BR_IND  = 3'd4;

   typedef struct packed {
      logic [RAS_PTR_W-1:0] ptr;
      logic [RAS_OCC_W-1:0] cnt;
      logic [31:0]          top;
   } ras_ckpt_t;

   function automatic logic [31:0] ras_ret_addr(input logic [31:0] pc);
      return {pc[31:2] + 30'd1, 2'b00};
   endfunction

endpackage

// File: rtl/ras_spec_ckpt_table.sv
// Per-branch-tag checkpoint register file: one write port, one combinational
// read port, cleared by the asynchronous reset.
module ras_ckpt_table
   import ras_spec_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wr_en,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  ras_ckpt_t        i_wr_data,
   input  logic [TAG_W-1:0] i_rd_tag,
   output ras_ckpt_t        o_rd_data
);

   ras_ckpt_t r_table [2**TAG_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2**TAG_W; i++) r_table[i] <= '0;
      end else if (i_wr_en) begin
         r_table[i_wr_tag] <= i_wr_data;
      end
   end

   assign o_rd_data = r_table[i_rd_tag];

endmodule

// File: rtl/ras_spec.sv
// Speculative return-address stack with per-branch checkpoint repair,
// committed-pointer shadow for flushes and overflow statistics.
module ras_spec
   import ras_spec_pkg::*;
#(
   parameter int DEPTH   = RAS_DEPTH,
   parameter int PTR_W   = $clog2(DEPTH),
   parameter int FETCH_W = 2,
   parameter int TAG_W   = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fetch_en,
   input  logic [FETCH_W-1:0]   slot_valid,
   input  logic [FETCH_W*3-1:0] slot_type,
   input  logic [FETCH_W*32-1:0] slot_pc,
   output logic [31:0]          pred_target,
   output logic                 pred_valid,
   input  logic                 ckpt_en,
   input  logic [TAG_W-1:0]     ckpt_tag,
   input  logic                 recover_en,
   input  logic [TAG_W-1:0]     recover_tag,
   input  logic [2:0]           recover_type,
   input  logic [31:0]          recover_pc,
   input  logic                 commit_en,
   input  logic [2:0]           commit_type,
   input  logic                 flush,
   output logic [CNT_W-1:0]     ovf_cnt
);

   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr, r_cptr;
   logic [OCC_W-1:0] r_cnt, r_ccnt;
   logic [CNT_W-1:0] r_ovf;

   logic             w_found, w_fetch_call, w_fetch_ret;
   logic [31:0]      w_fetch_pc, w_top, w_push_pc;
   logic             w_push, w_pop, w_ovf_inc, w_ckpt_we;
   logic [PTR_W-1:0] w_base_ptr, w_push_addr, w_nxt_ptr, w_cptr_nxt;
   logic [OCC_W-1:0] w_base_cnt, w_nxt_cnt, w_ccnt_nxt;
   ras_ckpt_t        w_ckpt_wr, w_ckpt_rd;

   assign w_top       = r_mem[r_ptr];
   assign pred_target = w_top;
   assign pred_valid  = (r_cnt != '0);
   assign ovf_cnt     = r_ovf;

   // Only the lowest-index valid CALL/RET slot drives the stack this cycle.
   always_comb begin
      w_found      = 1'b0;
      w_fetch_call = 1'b0;
      w_fetch_ret  = 1'b0;
      w_fetch_pc   = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (!w_found && slot_valid[i] &&
             (slot_type[i*3 +: 3] == BR_CALL || slot_type[i*3 +: 3] == BR_RET)) begin
            w_found      = 1'b1;
            w_fetch_call = (slot_type[i*3 +: 3] == BR_CALL);
            w_fetch_ret  = (slot_type[i*3 +: 3] == BR_RET);
            w_fetch_pc   = slot_pc[i*32 +: 32];
         end
      end
   end

   assign w_ckpt_we = fetch_en & ckpt_en & ~flush & ~recover_en;
   assign w_ckpt_wr = '{ptr: r_ptr, cnt: r_cnt, top: w_top};

   ras_ckpt_table #(.TAG_W(TAG_W)) u_ckpt (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_ckpt_we),
      .i_wr_tag  (ckpt_tag),
      .i_wr_data (w_ckpt_wr),
      .i_rd_tag  (recover_tag),
      .o_rd_data (w_ckpt_rd)
   );

   // A recovery replays its redo op on top of the restored checkpoint state.
   always_comb begin
      w_base_ptr = recover_en ? w_ckpt_rd.ptr : r_ptr;
      w_base_cnt = recover_en ? w_ckpt_rd.cnt : r_cnt;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_push_pc  = '0;
      if (flush) begin
         w_push = 1'b0;
      end else if (recover_en) begin
         w_push    = (recover_type == BR_CALL);
         w_pop     = (recover_type == BR_RET);
         w_push_pc = recover_pc;
      end else if (fetch_en) begin
         w_push    = w_fetch_call;
         w_pop     = w_fetch_ret;
         w_push_pc = w_fetch_pc;
      end
      w_push_addr = w_base_ptr + 1'b1;
      w_nxt_ptr   = w_base_ptr;
      w_nxt_cnt   = w_base_cnt;
      if (w_push) begin
         w_nxt_ptr = w_push_addr;
         if (w_base_cnt != FULL) w_nxt_cnt = w_base_cnt + 1'b1;
      end else if (w_pop && w_base_cnt != '0) begin
         w_nxt_ptr = w_base_ptr - 1'b1;
         w_nxt_cnt = w_base_cnt - 1'b1;
      end

      w_cptr_nxt = r_cptr;
      w_ccnt_nxt = r_ccnt;
      if (commit_en && commit_type == BR_CALL) begin
         w_cptr_nxt = r_cptr + 1'b1;
         if (r_ccnt != FULL) w_ccnt_nxt = r_ccnt + 1'b1;
      end else if (commit_en && commit_type == BR_RET && r_ccnt != '0) begin
         w_cptr_nxt = r_cptr - 1'b1;
         w_ccnt_nxt = r_ccnt - 1'b1;
      end

      if (flush) begin
         w_nxt_ptr = w_cptr_nxt;
         w_nxt_cnt = w_ccnt_nxt;
      end
   end

   assign w_ovf_inc = w_push && (w_base_cnt == FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr  <= '0;
         r_cnt  <= '0;
         r_cptr <= '0;
         r_ccnt <= '0;
         r_ovf  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_ptr  <= w_nxt_ptr;
         r_cnt  <= w_nxt_cnt;
         r_cptr <= w_cptr_nxt;
         r_ccnt <= w_ccnt_nxt;
         if (w_ovf_inc && r_ovf != '1) r_ovf <= r_ovf + 1'b1;
         // Repair and redo-push target different entries, so both may land together.
         if (recover_en && !flush) r_mem[w_ckpt_rd.ptr] <= w_ckpt_rd.top;
         if (w_push) r_mem[w_push_addr] <= ras_ret_addr(w_push_pc);
      end
   end

endmodule

// File: tb/tb_ras_spec.sv
// Self-checking bench for ras_spec: directed vectors, corner-case sequences and
// randomized traffic against a behavioural stack model.
module tb_ras_spec;
   import ras_spec_pkg::*;

   localparam int FW = 2;
   localparam int TW = 4;
   localparam int CW = 16;
   localparam int D  = 16;

   logic            clk, reset, fetch_en, ckpt_en, recover_en, commit_en, flush;
   logic [FW-1:0]   slot_valid;
   logic [FW*3-1:0] slot_type;
   logic [FW*32-1:0] slot_pc;
   logic [31:0]     pred_target, recover_pc;
   logic            pred_valid;
   logic [TW-1:0]   ckpt_tag, recover_tag;
   logic [2:0]      recover_type, commit_type;
   logic [CW-1:0]   ovf_cnt;

   ras_spec #(.DEPTH(D), .FETCH_W(FW), .TAG_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .slot_valid(slot_valid),
      .slot_type(slot_type), .slot_pc(slot_pc), .pred_target(pred_target),
      .pred_valid(pred_valid), .ckpt_en(ckpt_en), .ckpt_tag(ckpt_tag),
      .recover_en(recover_en), .recover_tag(recover_tag), .recover_type(recover_type),
      .recover_pc(recover_pc), .commit_en(commit_en), .commit_type(commit_type),
      .flush(flush), .ovf_cnt(ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: a circular array of return addresses plus counters.
   logic [31:0] m_mem [D];
   int          m_ptr, m_cnt, m_cptr, m_ccnt, m_ovf;
   int          t_ptr [16];
   int          t_cnt [16];
   logic [31:0] t_top [16];

   function automatic logic [31:0] ret_of(input logic [31:0] pc);
      return (pc & 32'hffff_fffc) + 32'd4;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      for (int i = 0; i < 16; i++) begin t_ptr[i] = 0; t_cnt[i] = 0; t_top[i] = '0; end
      m_ptr = 0; m_cnt = 0; m_cptr = 0; m_ccnt = 0; m_ovf = 0;
   endtask

   task automatic m_push(input logic [31:0] pc);
      m_ptr = (m_ptr + 1) % D;
      m_mem[m_ptr] = ret_of(pc);
      if (m_cnt == D) m_ovf = (m_ovf == 65535) ? 65535 : m_ovf + 1;
      else m_cnt++;
   endtask

   task automatic m_pop();
      if (m_cnt > 0) begin m_ptr = (m_ptr + D - 1) % D; m_cnt--; end
   endtask

   task automatic m_step();
      bit done = 0;
      if (commit_en && commit_type == BR_CALL) begin
         m_cptr = (m_cptr + 1) % D;
         if (m_ccnt < D) m_ccnt++;
      end else if (commit_en && commit_type == BR_RET && m_ccnt > 0) begin
         m_cptr = (m_cptr + D - 1) % D;
         m_ccnt--;
      end
      if (flush) begin
         m_ptr = m_cptr; m_cnt = m_ccnt;
      end else if (recover_en) begin
         m_ptr = t_ptr[recover_tag];
         m_cnt = t_cnt[recover_tag];
         m_mem[m_ptr] = t_top[recover_tag];
         if (recover_type == BR_CALL) m_push(recover_pc);
         else if (recover_type == BR_RET) m_pop();
      end else if (fetch_en) begin
         if (ckpt_en) begin
            t_ptr[ckpt_tag] = m_ptr; t_cnt[ckpt_tag] = m_cnt; t_top[ckpt_tag] = m_mem[m_ptr];
         end
         for (int i = 0; i < FW; i++) begin
            if (!done && slot_valid[i]) begin
               if (slot_type[i*3 +: 3] == BR_CALL) begin m_push(slot_pc[i*32 +: 32]); done = 1; end
               else if (slot_type[i*3 +: 3] == BR_RET) begin m_pop(); done = 1; end
            end
         end
      end
   endtask

   task automatic set_idle();
      fetch_en = 0; slot_valid = '0; slot_type = '0; slot_pc = '0;
      ckpt_en = 0; ckpt_tag = '0; recover_en = 0; recover_tag = '0;
      recover_type = BR_NOP; recover_pc = '0; commit_en = 0; commit_type = BR_NOP; flush = 0;
   endtask

   task automatic fetch1(input logic [2:0] t, input logic [31:0] pc);
      set_idle();
      fetch_en = 1; slot_valid = 2'b01; slot_type[2:0] = t; slot_pc[31:0] = pc;
   endtask

   task automatic step(input string name);
      m_step();
      @(posedge clk);
      #1;
      chk({name, " model valid"}, {31'b0, pred_valid}, {31'b0, (m_cnt != 0)});
      chk({name, " model target"}, pred_target, m_mem[m_ptr]);
      chk({name, " model ovf"}, {16'b0, ovf_cnt}, m_ovf);
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1;
      m_reset();
      @(posedge clk);
      #1;
      reset = 0;
      chk("reset valid", {31'b0, pred_valid}, 32'd0);
      chk("reset target", pred_target, 32'd0);
      chk("reset ovf", {16'b0, ovf_cnt}, 32'd0);
   endtask

   typedef struct {
      logic        fe;
      logic [1:0]  v;
      logic [2:0]  t0, t1;
      logic [31:0] pc0, pc1;
      logic        ev;
      logic [31:0] et;
   } vec_t;

   vec_t vecs [7];

   initial begin
      reset = 1;
      set_idle();
      m_reset();
      vecs[0] = '{1, 2'b01, BR_CALL, BR_NOP,  32'h1c000000, 32'h0,        1, 32'h1c000004};
      vecs[1] = '{1, 2'b01, BR_RET,  BR_NOP,  32'h1c000010, 32'h0,        0, 32'h0};
      vecs[2] = '{1, 2'b11, BR_COND, BR_CALL, 32'h1c0000fc, 32'h1c000100, 1, 32'h1c000104};
      vecs[3] = '{1, 2'b11, BR_CALL, BR_CALL, 32'h1c000200, 32'h1c000300, 1, 32'h1c000204};
      vecs[4] = '{1, 2'b11, BR_RET,  BR_CALL, 32'h1c000400, 32'h1c000500, 1, 32'h1c000104};
      vecs[5] = '{1, 2'b10, BR_CALL, BR_RET,  32'h1c000600, 32'h1c000700, 0, 32'h0};
      vecs[6] = '{0, 2'b01, BR_CALL, BR_NOP,  32'h1c000800, 32'h0,        0, 32'h0};
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 7; i++) begin
         set_idle();
         fetch_en = vecs[i].fe; slot_valid = vecs[i].v;
         slot_type = {vecs[i].t1, vecs[i].t0}; slot_pc = {vecs[i].pc1, vecs[i].pc0};
         step($sformatf("vec%0d", i));
         chk($sformatf("vec%0d valid", i), {31'b0, pred_valid}, {31'b0, vecs[i].ev});
         chk($sformatf("vec%0d target", i), pred_target, vecs[i].et);
      end

      // Overflow then underflow.
      do_reset();
      for (int i = 0; i < 17; i++) begin fetch1(BR_CALL, 32'h1000 + i * 32'h10); step("ovf call"); end
      chk("ovf count", {16'b0, ovf_cnt}, 32'd1);
      chk("ovf top", pred_target, 32'h1104);
      for (int i = 0; i < 15; i++) begin fetch1(BR_RET, 32'h0); step("ovf ret"); end
      chk("ret15 valid", {31'b0, pred_valid}, 32'd1);
      fetch1(BR_RET, 32'h0); step("ret16");
      chk("ret16 valid", {31'b0, pred_valid}, 32'd0);
      chk("ret16 target", pred_target, 32'h1104);
      fetch1(BR_RET, 32'h0); step("ret17");
      chk("underflow valid", {31'b0, pred_valid}, 32'd0);
      chk("underflow target", pred_target, 32'h1104);

      // Checkpoint and mispredict repair.
      do_reset();
      fetch1(BR_CALL, 32'h1c000000); step("ck callA");
      chk("ck A top", pred_target, 32'h1c000004);
      fetch1(BR_RET, 32'h0); ckpt_en = 1; ckpt_tag = 4'd3; step("ck wrong ret");
      chk("ck wrong ret valid", {31'b0, pred_valid}, 32'd0);
      fetch1(BR_CALL, 32'h1c000800); step("ck callB");
      chk("ck B top", pred_target, 32'h1c000804);
      set_idle(); recover_en = 1; recover_tag = 4'd3; recover_type = BR_NOP; step("rec none");
      chk("rec none top", pred_target, 32'h1c000004);
      chk("rec none valid", {31'b0, pred_valid}, 32'd1);
      set_idle(); recover_en = 1; recover_tag = 4'd3; recover_type = BR_CALL; recover_pc = 32'h200;
      step("rec call");
      chk("rec call top", pred_target, 32'h204);
      fetch1(BR_RET, 32'h0); step("rec ret1");
      chk("rec ret1 top", pred_target, 32'h1c000004);
      fetch1(BR_RET, 32'h0); step("rec ret2");
      chk("rec ret2 valid", {31'b0, pred_valid}, 32'd0);

      // Committed shadow and flush.
      do_reset();
      fetch1(BR_CALL, 32'h100); step("cm call1");
      fetch1(BR_CALL, 32'h200); commit_en = 1; commit_type = BR_CALL; step("cm call2");
      fetch1(BR_CALL, 32'h300); commit_en = 1; commit_type = BR_CALL; step("cm call3");
      chk("cm spec top", pred_target, 32'h304);
      set_idle(); flush = 1; commit_en = 1; commit_type = BR_RET; step("flush commit ret");
      chk("flush valid", {31'b0, pred_valid}, 32'd1);
      chk("flush top", pred_target, 32'h104);
      fetch1(BR_RET, 32'h0); step("flush ret");
      chk("flush ret valid", {31'b0, pred_valid}, 32'd0);
      set_idle(); flush = 1; step("flush again");
      chk("flush again top", pred_target, 32'h104);

      // Priority: flush beats recover and fetch, and blocks the checkpoint.
      do_reset();
      fetch1(BR_CALL, 32'h400); step("pri call");
      fetch1(BR_CALL, 32'h600); ckpt_en = 1; ckpt_tag = 4'd6; flush = 1;
      recover_en = 1; recover_tag = 4'd5; recover_type = BR_CALL; recover_pc = 32'h500;
      step("pri all");
      chk("pri valid", {31'b0, pred_valid}, 32'd0);
      chk("pri target", pred_target, 32'h0);
      set_idle(); recover_en = 1; recover_tag = 4'd6; recover_type = BR_NOP; step("pri no ckpt");
      chk("pri no ckpt valid", {31'b0, pred_valid}, 32'd0);

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         set_idle();
         fetch_en = ($urandom_range(0, 3) != 0);
         slot_valid = 2'($urandom);
         slot_type = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
         slot_pc = {$urandom, $urandom};
         ckpt_en = ($urandom_range(0, 3) == 0);
         ckpt_tag = 4'($urandom);
         recover_en = ($urandom_range(0, 15) == 0);
         recover_tag = 4'($urandom);
         recover_type = 3'($urandom_range(0, 4));
         recover_pc = $urandom;
         commit_en = ($urandom_range(0, 3) == 0);
         commit_type = ($urandom_range(0, 1) == 0) ? BR_CALL : BR_RET;
         flush = ($urandom_range(0, 31) == 0);
         step("rand");
      end

      // Asynchronous reset in the middle of a call burst.
      do_reset();
      for (int i = 0; i < 18; i++) begin fetch1(BR_CALL, 32'h2000 + i * 32'h8); step("burst"); end
      chk("burst ovf", {16'b0, ovf_cnt}, 32'd2);
      fetch1(BR_CALL, 32'h3000);
      #3;
      reset = 1;
      m_reset();
      #1;
      chk("async rst valid", {31'b0, pred_valid}, 32'd0);
      chk("async rst target", pred_target, 32'h0);
      chk("async rst ovf", {16'b0, ovf_cnt}, 32'd0);
      @(posedge clk);
      #1;
      reset = 0;
      set_idle();
      step("post rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ras_spec.md
Name: ras_spec

Overview:
- Parametrised speculative return-address stack; successor to the predictor's simple RAS.
- Sits beside the BTB/PHT in the fetch predictor.
- Supplies return targets to IF for up to FETCH_W slots per cycle.
- Adds per-branch checkpoints with mispredict repair (pointer, occupancy and top-entry content), a committed-pointer shadow for exception flush, and underflow/overflow tracking.

Parameters:
- DEPTH, 16, stack entries (power of 2).
- PTR_W, $clog2(DEPTH), stack pointer width.
- FETCH_W, 2, fetch slots examined per cycle.
- TAG_W, 4, branch-tag width; checkpoint table holds 2**TAG_W entries.
- CNT_W, 16, overflow statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch group accepted this cycle; RAS op may be applied.
- slot_valid  in  FETCH_W  slot valid mask.
- slot_type  in  FETCH_W*3  per-slot BR_* type from the shared definitions.
- slot_pc  in  FETCH_W*32  per-slot pc.
- pred_target  out  32  current top entry.
- pred_valid  out  1  stack non-empty.
- ckpt_en  in  1  save checkpoint for ckpt_tag.
- ckpt_tag  in  TAG_W  branch tag.
- recover_en  in  1  branch mispredict repair.
- recover_tag  in  TAG_W  tag to restore.
- recover_type  in  3  redo op: BR_CALL, BR_RET, or other = none.
- recover_pc  in  32  pc of the mispredicted branch.
- commit_en  in  1  retiring call/ret.
- commit_type  in  3  BR_CALL or BR_RET.
- flush  in  1  exception/ertn flush.
- ovf_cnt  out  CNT_W  saturating count of pushes made while full.

Behaviour:
- Op selection: lowest-index slot with slot_valid=1 and type BR_CALL or BR_RET. At most one op per cycle; later slots are ignored.
- Push (CALL): ptr<=ptr+1 (wraps mod DEPTH); mem[ptr+1]<={pc[31:2]+1,2'b00}; cnt<=min(cnt+1,DEPTH).
  - If cnt==DEPTH, the oldest entry is overwritten and ovf_cnt increments, saturating at all-ones.
- Pop (RET): if cnt!=0, ptr<=ptr-1 and cnt<=cnt-1. If cnt==0 (underflow), ptr and cnt are unchanged.
- pred_target = mem[ptr], combinational. pred_valid = (cnt!=0).
  - A RET and its target are resolved in the same cycle, from pre-op state.
- Checkpoint (ckpt_en, with fetch_en): table[ckpt_tag] <= {ptr, cnt, mem[ptr]}, the pre-op state of this cycle. It overwrites any prior entry for that tag.
- Recover: restores ptr/cnt from table[recover_tag] and writes mem[saved ptr] <= saved top, repairing a wrong-path overwrite. The redo op is then applied on top of the restored state:
  - CALL: ptr+1, write {recover_pc[31:2]+1,2'b00}, cnt update as for a push.
  - RET: pop rules as above.
  - CALL redo writes mem[saved ptr+1], distinct from the repair address. Both writes occur in the same cycle.
- Commit: committed shadow c_ptr/c_cnt follows the same push/pop/underflow rules. It has no storage of its own.
- Flush: ptr<=c_ptr and cnt<=c_cnt, using post-commit values when commit_en is asserted the same cycle. Contents are not repaired (accepted inaccuracy).
- Priority: flush > recover > fetch op.
  - Under flush or recover, the fetch op and ckpt_en of the same cycle are dropped.
  - commit_en is always honoured.
- Reset (asynchronous): ptr, cnt, c_ptr, c_cnt, ovf_cnt, mem and all table entries go to 0. Outputs are then pred_valid=0, pred_target=0, ovf_cnt=0.
  - Reset asserted mid-operation overrides all inputs immediately.
- Latency: all state updates are visible on the cycle after the triggering input.

Decomposition:
- Shared definitions package:
  - BR_NOP/BR_COND/BR_CALL/BR_RET/BR_IND encodings, reused unchanged.
  - New typedef ras_ckpt_t {ptr, cnt, top}.
  - Function ras_ret_addr(pc).
- One sub-module: ras_ckpt_table.
  - 2**TAG_W x ras_ckpt_t register file.
  - One write port (tag, data), one combinational read port, asynchronous reset.

Test Plan:
1. Reset, then CALL at pc 0x1c000000 in slot0 → next cycle pred_valid=1, pred_target=0x1c000004; RET → pred_valid=0, ptr=0.
2. Slot0 COND, slot1 CALL at 0x1c000100; then slot0 RET with slot1 CALL → only slot1 CALL pushed, then only slot0 RET popped; pred_target returns to prior top.
3. 17 CALLs with DEPTH=16 → cnt=16, ovf_cnt=1, top is the 17th address; 16 RETs then a 17th RET → pred_valid=0 and ptr unchanged on the 17th.
4. CALL A (top=A+4); ckpt tag 3 with a wrong-path RET; wrong-path CALL B overwrites the slot; recover tag 3 with type none → pred_target=A+4, cnt restored; recover with type CALL and pc 0x200 → top=0x204.
5. Commit two CALLs; speculative third CALL; flush with a simultaneous commit RET → ptr=c_ptr=1, cnt=1.
6. Flush, recover and fetch CALL in the same cycle → flush wins; no push, no checkpoint written. Assert reset mid-burst → all outputs 0 asynchronously.
